// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first, one bit per clock.
// Optional subtract mode when SERIAL_ADD_SUB_EN is defined (adds the 'sub' input).
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] res_full;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;

  logic accept;
  logic last_bit;
  logic sub_eff;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Full-adder cell built from two chained half adders plus an OR of their carries.
  logic ha0_s, ha0_c, ha1_s, ha1_c, cell_c;

  always_comb begin
    ha0_s  = a_sr_q[0] ^ b_sr_q[0];
    ha0_c  = a_sr_q[0] & b_sr_q[0];
    ha1_s  = ha0_s ^ carry_q;
    ha1_c  = ha0_s & carry_q;
    cell_c = ha0_c | ha1_c;
  end

  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_bit = (cnt_q == LastBit);

  // Sum bits enter from the MSB end; after WIDTH shifts bit 0 sits at the bottom.
  assign res_full = {ha1_s, res_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    s    = s_q;
    co   = co_q;
  end

  // Datapath next-state
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = sub_eff ? ~b : b;
      carry_d = sub_eff;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == StShift) begin
      a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
      res_d   = res_full[WIDTH-1:1];
      carry_d = cell_c;
      cnt_d   = cnt_q + CntW'(1);
      if (last_bit) begin
        s_d  = res_full;
        co_d = cell_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus random operations
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

  int n_tests = 0;
  int n_fail  = 0;

  // Result the DUT should currently be holding on s/co.
  logic [W-1:0] model_s = '0;
  logic         model_co = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {carry, sum}: plain modular arithmetic; in subtract mode carry means a >= b.
  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic op_sub);
    logic [W-1:0] diff;
    if (op_sub) begin
      diff = x - y;
      return {(x >= y), diff};
    end
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE/DONE and checks the whole timeline through cycle W+2.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_sub, input int glitch);
    logic [W:0] r;
    a = op_a;
    b = op_b;
    sub = op_sub;
    r = ref_result(op_a, op_b, sub);
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int k = 1; k <= int'(W); k++) begin
      check_eq("busy_shift", busy, 1);
      check_eq("done_early", done, 0);
      check_eq("s_hold", s, model_s);
      check_eq("co_hold", co, model_co);
      if (k == glitch) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check_eq("done_pulse", done, 1);
    check_eq("busy_in_done", busy, 0);
    check_eq("s_result", s, r[W-1:0]);
    check_eq("co_result", co, r[W]);
    model_s = r[W-1:0];
    model_co = r[W];
    tick();
    check_eq("done_drop", done, 0);
    check_eq("busy_idle", busy, 0);
    check_eq("s_after", s, model_s);
    check_eq("co_after", co, model_co);
  endtask

  initial begin
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_s", s, 0);
    check_eq("rst_co", co, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(8'h3C, 8'h05, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'h12, 8'h34, 1'b0, 3);

    // Held start: back-to-back operations, done at W+1 and 2W+2.
    a = 8'd1;
    b = 8'd2;
    sub = 1'b0;
    start = 1'b1;
    tick();
    a = 8'd3;
    b = 8'd4;
    for (int k = 1; k <= int'(2 * W + 2); k++) begin
      check_eq("held_done", done, (k == int'(W + 1)) || (k == int'(2 * W + 2)));
      check_eq("held_busy", busy, !((k == int'(W + 1)) || (k == int'(2 * W + 2))));
      if (k == int'(W + 1)) check_eq("held_s1", s, 3);
      if (k == int'(2 * W + 2)) begin
        check_eq("held_s2", s, 7);
        check_eq("held_co2", co, 0);
      end
      if (k == int'(W + 2)) start = 1'b0;
      tick();
    end
    model_s = 8'd7;
    model_co = 1'b0;

    // Asynchronous reset in cycle 4 of an operation.
    a = 8'h3C;
    b = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_s", s, 0);
    check_eq("arst_co", co, 0);
    model_s = '0;
    model_co = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(W + 3); k++) begin
      tick();
      check_eq("arst_no_done", done, 0);
      check_eq("arst_no_busy", busy, 0);
    end
    run_op(8'hA5, 8'h5A, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 0);
    run_op(8'h09, 8'h03, 1'b1, 0);
`endif

    for (int i = 0; i < 20; i++) begin
      logic rs;
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), rs, ($urandom_range(0, 3) == 0) ?
             int'($urandom_range(1, W - 1)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
